// File: rtl/trace_capture_buffer_pkg.sv
// Shared types and decode masks for the retire-trace capture buffer.
// Masks use '?' wildcards and are compared with ==?.
package trace_capture_buffer_pkg;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_MULDIV = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JUMP   = 3'd5,
    CLS_SYSTEM = 3'd6,
    CLS_OTHER  = 3'd7
  } trace_class_e;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_RING   = 2'd1,
    MODE_TRIG   = 2'd2,
    MODE_RSVD   = 2'd3
  } trace_mode_e;

  typedef enum logic [1:0] {
    TRIG_IDLE   = 2'd0,
    TRIG_ARMED  = 2'd1,
    TRIG_POST   = 2'd2,
    TRIG_FROZEN = 2'd3
  } trig_state_e;

  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  insn;
    logic [31:0]  wdata;
    logic [4:0]   rd;
    trace_class_e cls;
  } trace_entry_t;

  localparam logic [31:0] MSK_MULDIV =
    32'b0000001_?????_?????_???_?????_0110011;
  localparam logic [31:0] MSK_OP =
    32'b???????_?????_?????_???_?????_0110011;
  localparam logic [31:0] MSK_OP_IMM =
    32'b????????????_?????_???_?????_0010011;
  localparam logic [31:0] MSK_LUI =
    32'b????????????????????_?????_0110111;
  localparam logic [31:0] MSK_AUIPC =
    32'b????????????????????_?????_0010111;
  localparam logic [31:0] MSK_LOAD =
    32'b????????????_?????_???_?????_0000011;
  localparam logic [31:0] MSK_STORE =
    32'b???????_?????_?????_???_?????_0100011;
  localparam logic [31:0] MSK_BRANCH =
    32'b???????_?????_?????_???_?????_1100011;
  localparam logic [31:0] MSK_JAL =
    32'b????????????????????_?????_1101111;
  localparam logic [31:0] MSK_JALR =
    32'b????????????_?????_000_?????_1100111;
  // CSR ops: funct3 x01 and x1x (001,101,010,011,110,111)
  localparam logic [31:0] MSK_CSR_A =
    32'b????????????_?????_?01_?????_1110011;
  localparam logic [31:0] MSK_CSR_B =
    32'b????????????_?????_?1?_?????_1110011;
  localparam logic [31:0] MSK_ECALL  = 32'h0000_0073;
  localparam logic [31:0] MSK_EBREAK = 32'h0010_0073;
  localparam logic [31:0] MSK_MRET   = 32'h3020_0073;
  localparam logic [31:0] MSK_DRET   = 32'h7b20_0073;
  localparam logic [31:0] MSK_WFI    = 32'h1050_0073;
  localparam logic [31:0] MSK_FENCE =
    32'b????????????_?????_000_?????_0001111;
  localparam logic [31:0] MSK_FENCE_I =
    32'b????????????_?????_001_?????_0001111;

  function automatic logic overwrites(
    input trace_mode_e m
  );
    return (m == MODE_RING) || (m == MODE_TRIG);
  endfunction

endpackage

// File: rtl/trace_insn_classify.sv
// Combinational instruction classifier for the trace buffer.
// MULDIV is matched ahead of the generic OP pattern.
module trace_insn_classify
  import trace_capture_buffer_pkg::*;
(
  input  logic [31:0]  insn,
  output trace_class_e cls
);

  always_comb begin
    cls = CLS_OTHER;
    priority case (1'b1)
      (insn ==? MSK_MULDIV):  cls = CLS_MULDIV;
      (insn ==? MSK_OP):      cls = CLS_ALU;
      (insn ==? MSK_OP_IMM):  cls = CLS_ALU;
      (insn ==? MSK_LUI):     cls = CLS_ALU;
      (insn ==? MSK_AUIPC):   cls = CLS_ALU;
      (insn ==? MSK_LOAD):    cls = CLS_LOAD;
      (insn ==? MSK_STORE):   cls = CLS_STORE;
      (insn ==? MSK_BRANCH):  cls = CLS_BRANCH;
      (insn ==? MSK_JAL):     cls = CLS_JUMP;
      (insn ==? MSK_JALR):    cls = CLS_JUMP;
      (insn ==? MSK_CSR_A):   cls = CLS_SYSTEM;
      (insn ==? MSK_CSR_B):   cls = CLS_SYSTEM;
      (insn ==? MSK_ECALL):   cls = CLS_SYSTEM;
      (insn ==? MSK_EBREAK):  cls = CLS_SYSTEM;
      (insn ==? MSK_MRET):    cls = CLS_SYSTEM;
      (insn ==? MSK_DRET):    cls = CLS_SYSTEM;
      (insn ==? MSK_WFI):     cls = CLS_SYSTEM;
      (insn ==? MSK_FENCE):   cls = CLS_SYSTEM;
      (insn ==? MSK_FENCE_I): cls = CLS_SYSTEM;
      default:                cls = CLS_OTHER;
    endcase
  end

endmodule

// File: rtl/trace_capture_buffer.sv
// Retire-trace capture buffer: classify, filter, store, drain.
// Stream, ring and trigger capture modes with a lost-entry counter.
module trace_capture_buffer
  import trace_capture_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int DROP_W    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ret_valid_i,
  input  logic [31:0]            ret_pc_i,
  input  logic [31:0]            ret_insn_i,
  input  logic [31:0]            ret_wdata_i,
  input  logic [4:0]             ret_rd_i,
  input  logic [1:0]             mode_i,
  input  logic [7:0]             class_en_i,
  input  logic [31:0]            trig_pc_i,
  input  logic                   arm_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_pc_o,
  output logic [31:0]            out_insn_o,
  output logic [31:0]            out_wdata_o,
  output logic [4:0]             out_rd_o,
  output logic [2:0]             out_class_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DROP_W-1:0]      drop_cnt_o,
  output logic [1:0]             trig_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [PW-1:0] POST_LD = PW'(POST_TRIG);

  trace_entry_t mem [DEPTH];
  trace_entry_t head;
  trace_entry_t wentry;
  trace_class_e cls;
  trace_mode_e  mode;
  trig_state_e  state_q, state_d;

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     post_q, post_d;
  logic [CW-1:0]     count;
  logic [DROP_W-1:0] drop;

  logic full, ovw, cap_en;
  logic push, pop, wr_en, rd_adv;
  logic cnt_inc, cnt_dec, drop_inc;
  logic trig_hit;

  trace_insn_classify u_classify (
    .insn (ret_insn_i),
    .cls  (cls)
  );

  assign mode   = trace_mode_e'(mode_i);
  assign ovw    = overwrites(mode);
  assign full   = (count == CNT_FULL);
  assign cap_en = (state_q != TRIG_FROZEN);

  assign out_valid_o = (count != '0);

  assign push = ret_valid_i & class_en_i[cls]
              & cap_en & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  // Full + push without pop: ring/trigger evict the head
  assign wr_en    = push & (~full | pop | ovw);
  assign rd_adv   = pop | (push & full & ~pop & ovw);
  assign cnt_inc  = push & ~full & ~pop;
  assign cnt_dec  = pop & ~push;
  assign drop_inc = push & full & ~pop;
  assign trig_hit = push & (ret_pc_i == trig_pc_i);

  assign wentry = '{
    pc:    ret_pc_i,
    insn:  ret_insn_i,
    wdata: ret_wdata_i,
    rd:    ret_rd_i,
    cls:   cls
  };

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wentry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_adv) rd_ptr <= rd_ptr + PTR_ONE;
      if (cnt_inc)      count <= count + CNT_ONE;
      else if (cnt_dec) count <= count - CNT_ONE;
      if (drop_inc && (drop != '1))
        drop <= drop + DROP_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TRIG_IDLE;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
    end
  end

  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    if (flush_i || (mode != MODE_TRIG)) begin
      state_d = TRIG_IDLE;
      post_d  = '0;
    end else begin
      unique case (state_q)
        TRIG_IDLE: begin
          if (arm_i) state_d = TRIG_ARMED;
        end
        TRIG_ARMED: begin
          if (trig_hit) begin
            if (POST_TRIG == 0) begin
              state_d = TRIG_FROZEN;
            end else begin
              state_d = TRIG_POST;
              post_d  = POST_LD;
            end
          end
        end
        TRIG_POST: begin
          if (push) begin
            post_d = post_q - PTR_ONE;
            if (post_q == PTR_ONE)
              state_d = TRIG_FROZEN;
          end
        end
        TRIG_FROZEN: begin
          if (arm_i) state_d = TRIG_ARMED;
        end
        default: state_d = TRIG_IDLE;
      endcase
    end
  end

  // Empty buffer shows zeros rather than stale array contents
  assign head = out_valid_o ? mem[rd_ptr] : '0;

  assign out_pc_o     = head.pc;
  assign out_insn_o   = head.insn;
  assign out_wdata_o  = head.wdata;
  assign out_rd_o     = head.rd;
  assign out_class_o  = head.cls;
  assign count_o      = count;
  assign drop_cnt_o   = drop;
  assign trig_state_o = state_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Scoreboard bench for trace_capture_buffer (DEPTH=16, POST_TRIG=8).
// Stimulus queues expected drains; a negedge monitor checks each pop.
module tb_trace_capture_buffer;

  localparam int DEPTH  = 16;
  localparam int POST   = 8;
  localparam int DROP_W = 16;

  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] LW    = 32'h0000_A103;
  localparam logic [31:0] SW    = 32'h0020_A023;
  localparam logic [31:0] ADD   = 32'h0020_81B3;
  localparam logic [31:0] MUL   = 32'h02B5_0533;
  localparam logic [31:0] BEQ   = 32'h0020_8463;
  localparam logic [31:0] JAL   = 32'h0000_006F;
  localparam logic [31:0] JALR  = 32'h0000_8067;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] CSRRW = 32'h3401_1073;
  localparam logic [31:0] FENCE = 32'h0FF0_000F;
  localparam logic [31:0] FLW   = 32'h0000_2007;
  localparam logic [31:0] LUI   = 32'h0000_10B7;

  logic        clk;
  logic        rst_n;
  logic        ret_valid;
  logic [31:0] ret_pc, ret_insn, ret_wdata;
  logic [4:0]  ret_rd;
  logic [1:0]  mode;
  logic [7:0]  class_en;
  logic [31:0] trig_pc;
  logic        arm, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_insn, out_wdata;
  logic [4:0]  out_rd;
  logic [2:0]  out_class;
  logic [$clog2(DEPTH):0] count;
  logic [DROP_W-1:0]      drop_cnt;
  logic [1:0]             trig_state;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [2:0]  cls;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  trace_capture_buffer #(
    .DEPTH(DEPTH), .POST_TRIG(POST), .DROP_W(DROP_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ret_valid_i  (ret_valid),
    .ret_pc_i     (ret_pc),
    .ret_insn_i   (ret_insn),
    .ret_wdata_i  (ret_wdata),
    .ret_rd_i     (ret_rd),
    .mode_i       (mode),
    .class_en_i   (class_en),
    .trig_pc_i    (trig_pc),
    .arm_i        (arm),
    .flush_i      (flush),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_pc_o     (out_pc),
    .out_insn_o   (out_insn),
    .out_wdata_o  (out_wdata),
    .out_rd_o     (out_rd),
    .out_class_o  (out_class),
    .count_o      (count),
    .drop_cnt_o   (drop_cnt),
    .trig_state_o (trig_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got pc=%h want none",
                 out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_pc !== mon_e.pc
            || out_insn !== mon_e.insn
            || out_class !== mon_e.cls
            || out_wdata !== (mon_e.pc ^ 32'hA5A5_0000)
            || out_rd !== mon_e.pc[6:2]) begin
          bad++;
          $display("FAIL pop got pc=%h insn=%h cls=%0d want pc=%h insn=%h cls=%0d",
                   out_pc, out_insn, out_class,
                   mon_e.pc, mon_e.insn, mon_e.cls);
        end
      end
    end
  end

  function automatic logic [31:0] pcn(input int i);
    return 32'h1000 + 32'(i) * 32'd4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc,
                      input logic [31:0] insn);
    ret_valid = 1'b1;
    ret_pc    = pc;
    ret_insn  = insn;
    ret_wdata = pc ^ 32'hA5A5_0000;
    ret_rd    = pc[6:2];
    step();
    ret_valid = 1'b0;
  endtask

  task automatic expect_e(input logic [31:0] pc,
                          input logic [31:0] insn,
                          input logic [2:0] cls);
    exp_t e;
    e.pc = pc;
    e.insn = insn;
    e.cls = cls;
    exp_q.push_back(e);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((count != 0 || exp_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    check({nm, "_left"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_cnt0"}, 64'(count), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    ret_valid = 1'b0;
    ret_pc = '0;
    ret_insn = '0;
    ret_wdata = '0;
    ret_rd = '0;
    mode = 2'b00;
    class_en = 8'hFF;
    trig_pc = '0;
    arm = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;

    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_state", 64'(trig_state), 64'd0);
    check("rst_pc", 64'(out_pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // stream: first 16 kept, 4 lost
    mode = 2'b00;
    for (int i = 1; i <= 20; i++) push(pcn(i), ADDI);
    check("stream_count", 64'(count), 64'd16);
    check("stream_drop", 64'(drop_cnt), 64'd4);
    check("stream_head", 64'(out_pc), 64'(pcn(1)));
    for (int i = 1; i <= 16; i++) expect_e(pcn(i), ADDI, 3'd0);
    drain("stream");

    // ring: last 16 kept
    pulse_flush();
    check("flush_drop", 64'(drop_cnt), 64'd0);
    mode = 2'b01;
    for (int i = 1; i <= 20; i++) push(pcn(i), ADDI);
    check("ring_count", 64'(count), 64'd16);
    check("ring_drop", 64'(drop_cnt), 64'd4);
    check("ring_head", 64'(out_pc), 64'(pcn(5)));
    for (int i = 5; i <= 20; i++) expect_e(pcn(i), ADDI, 3'd0);
    drain("ring");

    // trigger at push 12, freeze after push 20
    mode = 2'b10;
    pulse_flush();
    check("trig_idle", 64'(trig_state), 64'd0);
    trig_pc = pcn(12);
    pulse_arm();
    check("trig_armed", 64'(trig_state), 64'd1);
    for (int i = 1; i <= 30; i++) begin
      push(pcn(i), ADDI);
      if (i == 12) check("trig_post", 64'(trig_state), 64'd2);
      if (i == 19) check("trig_post19", 64'(trig_state), 64'd2);
      if (i == 20) check("trig_frozen", 64'(trig_state), 64'd3);
    end
    check("trig_count", 64'(count), 64'd16);
    check("trig_drop", 64'(drop_cnt), 64'd4);
    check("trig_state_end", 64'(trig_state), 64'd3);
    for (int i = 5; i <= 20; i++) expect_e(pcn(i), ADDI, 3'd0);
    drain("trig");
    pulse_arm();
    check("trig_rearm", 64'(trig_state), 64'd1);

    // class filter: loads only
    mode = 2'b00;
    pulse_flush();
    class_en = 8'b0000_0100;
    push(pcn(1), LW);
    push(pcn(2), SW);
    push(pcn(3), ADD);
    push(pcn(4), MUL);
    push(pcn(5), LW);
    check("filt_count", 64'(count), 64'd2);
    check("filt_drop", 64'(drop_cnt), 64'd0);
    expect_e(pcn(1), LW, 3'd2);
    expect_e(pcn(5), LW, 3'd2);
    drain("filt");
    class_en = 8'b0000_0010;
    push(pcn(6), ADD);
    push(pcn(7), MUL);
    check("muldiv_count", 64'(count), 64'd1);
    expect_e(pcn(7), MUL, 3'd1);
    drain("muldiv");

    // every class once
    class_en = 8'hFF;
    push(pcn(1), LUI);   expect_e(pcn(1), LUI, 3'd0);
    push(pcn(2), ADD);   expect_e(pcn(2), ADD, 3'd0);
    push(pcn(3), MUL);   expect_e(pcn(3), MUL, 3'd1);
    push(pcn(4), LW);    expect_e(pcn(4), LW, 3'd2);
    push(pcn(5), SW);    expect_e(pcn(5), SW, 3'd3);
    push(pcn(6), BEQ);   expect_e(pcn(6), BEQ, 3'd4);
    push(pcn(7), JAL);   expect_e(pcn(7), JAL, 3'd5);
    push(pcn(8), JALR);  expect_e(pcn(8), JALR, 3'd5);
    push(pcn(9), ECALL); expect_e(pcn(9), ECALL, 3'd6);
    push(pcn(10), CSRRW); expect_e(pcn(10), CSRRW, 3'd6);
    push(pcn(11), FENCE); expect_e(pcn(11), FENCE, 3'd6);
    push(pcn(12), FLW);  expect_e(pcn(12), FLW, 3'd7);
    check("cls_count", 64'(count), 64'd12);
    drain("cls");

    // full with push+pop every cycle
    mode = 2'b01;
    pulse_flush();
    for (int i = 1; i <= 16; i++) begin
      push(pcn(i), ADDI);
      expect_e(pcn(i), ADDI, 3'd0);
    end
    out_ready = 1'b1;
    for (int i = 17; i <= 66; i++) begin
      expect_e(pcn(i), ADDI, 3'd0);
      push(pcn(i), ADDI);
      check("pp_count", 64'(count), 64'd16);
    end
    check("pp_drop", 64'(drop_cnt), 64'd0);
    drain("pp");

    // flush+arm during POST: flush wins
    mode = 2'b10;
    pulse_flush();
    trig_pc = pcn(3);
    pulse_arm();
    for (int i = 1; i <= 5; i++) push(pcn(i), ADDI);
    check("fa_post", 64'(trig_state), 64'd2);
    check("fa_pre_cnt", 64'(count), 64'd5);
    flush = 1'b1;
    arm = 1'b1;
    ret_valid = 1'b1;
    ret_pc = pcn(6);
    step();
    flush = 1'b0;
    arm = 1'b0;
    ret_valid = 1'b0;
    check("fa_count", 64'(count), 64'd0);
    check("fa_state", 64'(trig_state), 64'd0);
    check("fa_valid", 64'(out_valid), 64'd0);

    // async reset mid-drain
    mode = 2'b00;
    for (int i = 1; i <= 18; i++) push(pcn(i), ADDI);
    check("rd_drop", 64'(drop_cnt), 64'd2);
    for (int i = 1; i <= 16; i++) expect_e(pcn(i), ADDI, 3'd0);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check("rd_cnt", 64'(count), 64'd14);
    check("rd_left", 64'(exp_q.size()), 64'd14);
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_drop", 64'(drop_cnt), 64'd0);
    check("ar_state", 64'(trig_state), 64'd0);
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_pc", 64'(out_pc), 64'd0);
    check("ar_insn", 64'(out_insn), 64'd0);
    check("ar_wdata", 64'(out_wdata), 64'd0);
    check("ar_rd_cls", 64'({out_rd, out_class}), 64'd0);
    step();
    step();
    check("ar_hold_cnt", 64'(count), 64'd0);
    rst_n = 1'b1;
    step();
    push(pcn(40), LW);
    expect_e(pcn(40), LW, 3'd2);
    check("post_rst_cnt", 64'(count), 64'd1);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
